// File: rtl/armleocpu_regfile_wrctrl_if.sv
// Purpose: bundles the writeback and debug write-request channels with the
// register file write port they arbitrate onto.
// Ports: wb_* / dbg_* valid-ready request channels in, rd_* write port out.
interface armleocpu_regfile_wrctrl_if;
    // Pipeline writeback request channel
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_wdata;

    // Debug register-write request channel
    logic        dbg_valid;
    logic        dbg_ready;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;

    // Registered register-file write port
    logic        rd_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;

    // Requester / consumer side
    modport master (
        output wb_valid, wb_addr, wb_wdata,
        input  wb_ready,
        output dbg_valid, dbg_addr, dbg_wdata,
        input  dbg_ready,
        input  rd_write, rd_addr, rd_wdata
    );

    // Write controller side
    modport slave (
        input  wb_valid, wb_addr, wb_wdata,
        output wb_ready,
        input  dbg_valid, dbg_addr, dbg_wdata,
        output dbg_ready,
        output rd_write, rd_addr, rd_wdata
    );
endinterface

// File: rtl/armleocpu_regfile_wrctrl.sv
// Purpose: clears x0..x31 after reset, then arbitrates writeback vs debug writes onto the regfile write port.
// Latency: one cycle from a valid&&ready handshake to the registered rd_* write port.
// Backpressure: both readies low while clearing; writeback wins ties unless debug has starved STARVE_LIMIT times.
//
// Ports: clk, rst_n (async active-low), bus (slave side of armleocpu_regfile_wrctrl_if),
//        init_done (high once the 32-register clear has completed, until next reset).
module armleocpu_regfile_wrctrl #(
    parameter int unsigned STARVE_LIMIT = 4   // legal range 1..15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    armleocpu_regfile_wrctrl_if.slave     bus,
    output logic                          init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [4:0]  clr_cnt_q, clr_cnt_d;
    logic [3:0]  starve_q, starve_d;
    logic        rd_write_q, rd_write_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_wdata_q, rd_wdata_d;
    logic        init_done_q, init_done_d;

    logic        forced;
    logic        wb_rdy;
    logic        dbg_rdy;
    logic        wb_xfer;
    logic        dbg_xfer;

    // Readies come straight from registered state, so reset forces them low
    // asynchronously. dbg_ready looks at wb_valid (the other requester), never
    // at dbg_valid, so neither requester's ready depends on its own valid.
    assign forced   = (state_q == ST_RUN) && (starve_q == LIMIT);
    assign wb_rdy   = (state_q == ST_RUN) && !forced;
    assign dbg_rdy  = (state_q == ST_RUN) && (forced || !bus.wb_valid);
    assign wb_xfer  = bus.wb_valid && wb_rdy;
    assign dbg_xfer = bus.dbg_valid && dbg_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= 5'd0;
            starve_q    <= 4'd0;
            rd_write_q  <= 1'b0;
            rd_addr_q   <= 5'd0;
            rd_wdata_q  <= 32'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            starve_q    <= starve_d;
            rd_write_q  <= rd_write_d;
            rd_addr_q   <= rd_addr_d;
            rd_wdata_q  <= rd_wdata_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        starve_d    = starve_q;
        rd_write_d  = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_wdata_d  = rd_wdata_q;
        init_done_d = init_done_q;

        unique case (state_q)
            ST_INIT: begin
                rd_write_d = 1'b1;
                rd_addr_d  = clr_cnt_q;
                rd_wdata_d = 32'd0;
                clr_cnt_d  = clr_cnt_q + 5'd1;
                if (clr_cnt_q == 5'd31) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                // The ready equations make the two transfers mutually exclusive.
                if (wb_xfer) begin
                    rd_write_d = (bus.wb_addr != 5'd0);
                    rd_addr_d  = bus.wb_addr;
                    rd_wdata_d = bus.wb_wdata;
                end else if (dbg_xfer) begin
                    rd_write_d = (bus.dbg_addr != 5'd0);
                    rd_addr_d  = bus.dbg_addr;
                    rd_wdata_d = bus.dbg_wdata;
                end

                // Count debug losses; once at LIMIT, wb_ready drops so the
                // count holds until debug finally transfers.
                if (dbg_xfer || !bus.dbg_valid) begin
                    starve_d = 4'd0;
                end else if (wb_xfer) begin
                    starve_d = starve_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign bus.wb_ready  = wb_rdy;
    assign bus.dbg_ready = dbg_rdy;
    assign bus.rd_write  = rd_write_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_wdata  = rd_wdata_q;
    assign init_done     = init_done_q;

endmodule

// File: tb/tb_armleocpu_regfile_wrctrl.sv
// Directed bench for armleocpu_regfile_wrctrl: clear sequence, writeback and
// debug transfers, x0 suppression, starvation forcing, mid-clear reset.
module tb_armleocpu_regfile_wrctrl;

    logic clk;
    logic rst_n;
    logic init_done;

    int errors = 0;
    int checks = 0;

    armleocpu_regfile_wrctrl_if bus ();

    armleocpu_regfile_wrctrl #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rd_write"},  {31'd0, bus.rd_write},  32'd0);
        chk({tag, ".rd_addr"},   {27'd0, bus.rd_addr},   32'd0);
        chk({tag, ".rd_wdata"},  bus.rd_wdata,           32'd0);
        chk({tag, ".init_done"}, {31'd0, init_done},     32'd0);
        chk({tag, ".wb_ready"},  {31'd0, bus.wb_ready},  32'd0);
        chk({tag, ".dbg_ready"}, {31'd0, bus.dbg_ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_data;
        logic [4:0]  exp_addr;
        bit          dbg_turn;

        rst_n         = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = 5'd0;
        bus.wb_wdata  = 32'd0;
        bus.dbg_valid = 1'b0;
        bus.dbg_addr  = 5'd0;
        bus.dbg_wdata = 32'd0;

        // Reset state
        #13;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full clear: 32 writes of zero to x0..x31, init_done with the last
        for (int i = 0; i < 32; i++) begin
            tick();
            chk($sformatf("clr%0d.rd_write", i), {31'd0, bus.rd_write}, 32'd1);
            chk($sformatf("clr%0d.rd_addr", i), {27'd0, bus.rd_addr}, i);
            chk($sformatf("clr%0d.rd_wdata", i), bus.rd_wdata, 32'd0);
            chk($sformatf("clr%0d.init_done", i), {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
            if (i < 31) chk($sformatf("clr%0d.wb_ready", i), {31'd0, bus.wb_ready}, 32'd0);
        end
        chk("run.wb_ready", {31'd0, bus.wb_ready}, 32'd1);
        chk("run.dbg_ready", {31'd0, bus.dbg_ready}, 32'd1);
        tick();
        chk("idle.rd_write", {31'd0, bus.rd_write}, 32'd0);
        chk("idle.init_done", {31'd0, init_done}, 32'd1);

        // Single writeback transfer to x5
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd5;
        bus.wb_wdata = 32'hDEADBEEF;
        #1;
        chk("wb1.wb_ready", {31'd0, bus.wb_ready}, 32'd1);
        chk("wb1.dbg_ready_blocked", {31'd0, bus.dbg_ready}, 32'd0);
        tick();
        bus.wb_valid = 1'b0;
        chk("wb1.rd_write", {31'd0, bus.rd_write}, 32'd1);
        chk("wb1.rd_addr", {27'd0, bus.rd_addr}, 32'd5);
        chk("wb1.rd_wdata", bus.rd_wdata, 32'hDEADBEEF);
        tick();
        chk("wb1.after.rd_write", {31'd0, bus.rd_write}, 32'd0);
        chk("wb1.after.rd_addr_hold", {27'd0, bus.rd_addr}, 32'd5);
        chk("wb1.after.rd_wdata_hold", bus.rd_wdata, 32'hDEADBEEF);

        // Debug write to x0: handshake completes, no register write
        bus.dbg_valid = 1'b1;
        bus.dbg_addr  = 5'd0;
        bus.dbg_wdata = 32'h00001234;
        #1;
        chk("dbg0.dbg_ready", {31'd0, bus.dbg_ready}, 32'd1);
        tick();
        bus.dbg_valid = 1'b0;
        chk("dbg0.rd_write", {31'd0, bus.rd_write}, 32'd0);
        chk("dbg0.rd_addr", {27'd0, bus.rd_addr}, 32'd0);
        chk("dbg0.rd_wdata", bus.rd_wdata, 32'h00001234);
        tick();
        chk("dbg0.after.rd_write", {31'd0, bus.rd_write}, 32'd0);

        // Continuous contention: wb,wb,wb,wb,dbg repeating
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd3;
        bus.wb_wdata  = 32'h00001000;
        bus.dbg_valid = 1'b1;
        bus.dbg_addr  = 5'd7;
        bus.dbg_wdata = 32'h00002000;
        for (int k = 0; k < 10; k++) begin
            #1;
            dbg_turn = ((k % 5) == 4);
            chk($sformatf("starve%0d.wb_ready", k), {31'd0, bus.wb_ready}, dbg_turn ? 32'd0 : 32'd1);
            chk($sformatf("starve%0d.dbg_ready", k), {31'd0, bus.dbg_ready}, dbg_turn ? 32'd1 : 32'd0);
            exp_data = dbg_turn ? bus.dbg_wdata : bus.wb_wdata;
            exp_addr = dbg_turn ? 5'd7 : 5'd3;
            tick();
            chk($sformatf("starve%0d.rd_write", k), {31'd0, bus.rd_write}, 32'd1);
            chk($sformatf("starve%0d.rd_addr", k), {27'd0, bus.rd_addr}, {27'd0, exp_addr});
            chk($sformatf("starve%0d.rd_wdata", k), bus.rd_wdata, exp_data);
            // Only the channel that just transferred presents new data
            if (dbg_turn) bus.dbg_wdata = 32'h00002000 + k + 1;
            else          bus.wb_wdata  = 32'h00001000 + k + 1;
        end

        // Dropping dbg_valid clears the starvation count
        bus.dbg_valid = 1'b0;
        tick();
        tick();
        tick();                     // two contended losses then a gap below
        bus.dbg_valid = 1'b1;
        tick();
        tick();                     // count now 2
        bus.dbg_valid = 1'b0;
        tick();                     // count cleared
        bus.dbg_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("clear%0d.wb_ready", k), {31'd0, bus.wb_ready}, 32'd1);
            tick();
        end
        #1;
        chk("clear.forced.wb_ready", {31'd0, bus.wb_ready}, 32'd0);
        chk("clear.forced.dbg_ready", {31'd0, bus.dbg_ready}, 32'd1);
        bus.wb_valid  = 1'b0;
        bus.dbg_valid = 1'b0;
        tick();
        tick();

        // Reset mid-clear with a writeback request held through INIT
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_run.rd_write", {31'd0, bus.rd_write}, 32'd0);
        chk("rst_run.init_done", {31'd0, init_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd9;
        for (int i = 0; i < 10; i++) begin
            bus.wb_wdata = 32'hA0000000 + i;
            tick();
            chk($sformatf("part%0d.rd_addr", i), {27'd0, bus.rd_addr}, i);
            chk($sformatf("part%0d.rd_wdata", i), bus.rd_wdata, 32'd0);
            chk($sformatf("part%0d.wb_ready", i), {31'd0, bus.wb_ready}, 32'd0);
        end
        // Clear counter is 10 here
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        tick();
        tick();
        chk_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.wb_wdata = 32'hB0000000 + i;
            tick();
            chk($sformatf("reclr%0d.rd_addr", i), {27'd0, bus.rd_addr}, i);
            chk($sformatf("reclr%0d.rd_wdata", i), bus.rd_wdata, 32'd0);
            chk($sformatf("reclr%0d.init_done", i), {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
        end
        bus.wb_wdata = 32'hCAFEF00D;
        #1;
        chk("held.wb_ready", {31'd0, bus.wb_ready}, 32'd1);
        tick();
        bus.wb_valid = 1'b0;
        chk("held.rd_write", {31'd0, bus.rd_write}, 32'd1);
        chk("held.rd_addr", {27'd0, bus.rd_addr}, 32'd9);
        chk("held.rd_wdata", bus.rd_wdata, 32'hCAFEF00D);
        tick();
        chk("held.after.rd_write", {31'd0, bus.rd_write}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
